regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the 5-stage core and its dual-issue follow-on.
- Provides NRD read ports and NWR write ports with write-to-read bypass and an optional hardwired zero register.
- An integrated scoreboard tracks destination registers with outstanding writes, so decode can detect RAW hazards without a separate unit.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, at least 2.
- NRD, 2, number of read ports; 1 to 4.
- NWR, 2, number of write ports; 1 to 2.
- ZERO_REG, 1, when 1, register 0 always reads 0 and is never written or marked busy.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all registers, the scoreboard and the count.
- rd_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NRD*WIDTH  read data, combinational.
- rd_busy  out  NRD  per-port flag: the addressed register has a pending write.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*WIDTH  write data.
- iss_en  in  1  an instruction with a destination register is issuing.
- iss_addr  in  AW  destination register of the issuing instruction.
- flush  in  1  synchronous clear of all scoreboard bits; register contents are untouched.
- busy_count  out  $clog2(DEPTH+1)  number of registers currently marked busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers go to 0, all scoreboard bits go to 0, busy_count goes to 0.
  - rd_busy therefore reads 0, and rd_data reads 0 for every address.
  - Reset asserted mid-operation discards any in-flight write or issue in that cycle.
- Write:
  - On the rising edge, for each port j with wr_en[j]=1, the register at wr_addr[j] takes wr_data[j].
  - If two ports write the same address in one cycle, the higher port index wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read:
  - Combinational; zero-cycle latency.
  - Bypass: if any enabled write port targets rd_addr[k] in the same cycle, rd_data[k] returns that wr_data (highest matching port index); otherwise it returns the stored value.
  - With ZERO_REG=1, a read of address 0 returns 0 regardless of any bypass.
- Scoreboard (DEPTH bits, sb):
  - Set: iss_en=1 sets sb[iss_addr] at the edge.
  - Clear: any enabled write clears sb[wr_addr[j]] at the edge.
  - Priority at one edge: flush over set over clear. With flush=1, every bit goes to 0 and iss_en is ignored. If iss_addr equals a write address in the same cycle, the bit ends up set (the new producer is pending).
  - With ZERO_REG=1, bit 0 is tied to 0.
- rd_busy[k] = sb[rd_addr[k]] AND NOT (a write to rd_addr[k] this cycle).
  - A register being written this cycle is reported not busy, consistent with the bypassed data.
  - rd_busy[k] is 0 for address 0 when ZERO_REG=1.
- busy_count:
  - Registered popcount of next-state sb, updated at the same edge as sb.
  - Never exceeds DEPTH-ZERO_REG; flush forces it to 0.
  - Implemented as a registered next-state popcount, not an incremental counter, so simultaneous set and clears cannot drift.
- No handshake back-pressure: the block accepts every write and issue every cycle.

Decomposition:
- Shared package (core_pkg): default WIDTH and DEPTH, the ZERO_REG default, and a function for the AW derivation and popcount.
- One natural sub-module, regfile_scoreboard: the sb vector, set/clear/flush priority, busy lookup and busy_count.
- Storage, write arbitration and bypass muxing stay in the top level.

Test Plan:
- Reset: assert reset with a mid-cycle write of 0xDEADBEEF to r5 → after release, r5 reads 0, rd_busy=0, busy_count=0.
- Dual-port collision: wr0 writes r3=0x11 and wr1 writes r3=0x22 in the same cycle → rd_data for r3 shows 0x22 in that cycle (bypass) and on the next cycle (stored).
- Zero register: write r0=0xFFFFFFFF and issue r0 → reads 0, rd_busy=0, busy_count stays 0; repeat with ZERO_REG=0 → reads 0xFFFFFFFF.
- Scoreboard lifecycle: issue r7, then r9 → busy_count 1 then 2 and rd_busy set for r7; write r7 → rd_busy low in the write cycle, busy_count=1 after the edge.
- Same-cycle issue and write of r4 (r4 already busy) → r4 stays busy and busy_count is unchanged.
- Flush: with r2, r6 and r8 busy, assert flush together with iss_en on r10 → all rd_busy=0, busy_count=0, r10 not busy, and register contents unchanged.

Source files
------------

// File: rtl/core_pkg.sv
// Shared defaults and helpers for the register file slice.
// Holds the AW derivation and the popcount used by the scoreboard.
package core_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int DEPTH_DEF    = 32;
    localparam int ZERO_REG_DEF = 1;
    localparam int POP_MAX      = 1024;

    function automatic int addr_width(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) w++;
        return w;
    endfunction

    function automatic int popcount(input logic [POP_MAX-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) n += int'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: flush > set > clear at each edge.
// busy_count is the registered popcount of the next-state vector.
module regfile_scoreboard
    import core_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int AW       = addr_width(DEPTH),
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    output logic [CW-1:0]     busy_count
);

    logic [DEPTH-1:0]   sb;
    logic [DEPTH-1:0]   sb_nxt;
    logic [POP_MAX-1:0] sb_ext;
    logic [NRD-1:0]     hit;
    logic [AW-1:0]      ra [NRD];
    logic [AW-1:0]      wa [NWR];

    for (genvar k = 0; k < NRD; k++) begin : g_ra
        assign ra[k] = rd_addr[k*AW +: AW];
    end
    for (genvar j = 0; j < NWR; j++) begin : g_wa
        assign wa[j] = wr_addr[j*AW +: AW];
    end

    // Next-state vector: clears first, then set, flush overrides all.
    always_comb begin
        sb_nxt = sb;
        for (int j = 0; j < NWR; j++)
            if (wr_en[j]) sb_nxt[wa[j]] = 1'b0;
        if (iss_en) sb_nxt[iss_addr] = 1'b1;
        if (flush) sb_nxt = '0;
        if (ZERO_REG != 0) sb_nxt[0] = 1'b0;
    end

    // Zero-extend for the shared popcount helper.
    always_comb begin
        sb_ext = '0;
        sb_ext[DEPTH-1:0] = sb_nxt;
    end

    // Scoreboard and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb         <= '0;
            busy_count <= '0;
        end else begin
            sb         <= sb_nxt;
            busy_count <= CW'(popcount(sb_ext));
        end
    end

    // A register being written this cycle is not reported busy.
    always_comb begin
        hit = '0;
        for (int k = 0; k < NRD; k++)
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wa[j] == ra[k]) hit[k] = 1'b1;
    end

    // Per-port busy lookup.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NRD; k++)
            rd_busy[k] = sb[ra[k]] & ~hit[k];
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass and scoreboard.
// Storage, write arbitration and bypass live here.
module regfile_mp_sb
    import core_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = ZERO_REG_DEF,
    localparam int AW      = addr_width(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*WIDTH-1:0] wr_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic                 flush,
    output logic [CW-1:0]        busy_count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ra  [NRD];
    logic [AW-1:0]    wa  [NWR];
    logic [WIDTH-1:0] wd  [NWR];

    for (genvar k = 0; k < NRD; k++) begin : g_ra
        assign ra[k] = rd_addr[k*AW +: AW];
    end
    for (genvar j = 0; j < NWR; j++) begin : g_w
        assign wa[j] = wr_addr[j*AW +: AW];
        assign wd[j] = wr_data[j*WIDTH +: WIDTH];
    end

    // Storage; later ports overwrite earlier ones on an address clash.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && !(ZERO_REG != 0 && wa[j] == '0))
                    mem[wa[j]] <= wd[j];
        end
    end

    // Read mux with bypass; highest matching write port wins.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_data[k*WIDTH +: WIDTH] = mem[ra[k]];
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wa[j] == ra[k])
                    rd_data[k*WIDTH +: WIDTH] = wd[j];
            if (ZERO_REG != 0 && ra[k] == '0)
                rd_data[k*WIDTH +: WIDTH] = '0;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW),
        .CW       (CW)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb, default and ZERO_REG=0 builds.
// Expected values are hand-computed per step.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_z;
    logic [1:0]  rd_busy, rd_busy_z;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [5:0]  busy_count, busy_count_z;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_mp_sb u_dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .flush      (flush),
        .busy_count (busy_count)
    );

    regfile_mp_sb #(.ZERO_REG(0)) u_nz (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data_z),
        .rd_busy    (rd_busy_z),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .flush      (flush),
        .busy_count (busy_count_z)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic issue(input logic [4:0] a);
        iss_en   = 1'b1;
        iss_addr = a;
        step();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        rd(5'd5, 5'd0);
        check("rst_data", rd_data[31:0], 32'h0);
        check("rst_cnt", 32'(busy_count), 32'd0);

        // reset asserted while a write and issue to r5 are pending
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5};
        wr_data = {32'h0, 32'hDEADBEEF};
        iss_en = 1'b1; iss_addr = 5'd5;
        #2 reset = 1'b0;
        @(posedge clk);
        #1 idle();
        #2 reset = 1'b1;
        rd(5'd5, 5'd5);
        check("rst_mid_data", rd_data[31:0], 32'h0);
        check("rst_mid_busy", 32'(rd_busy), 32'd0);
        check("rst_mid_cnt", 32'(busy_count), 32'd0);

        // dual-port collision on r3
        wr_en = 2'b11; wr_addr = {5'd3, 5'd3};
        wr_data = {32'h22, 32'h11};
        rd(5'd3, 5'd3);
        check("coll_bypass", rd_data[31:0], 32'h22);
        step();
        rd(5'd3, 5'd0);
        check("coll_stored", rd_data[31:0], 32'h22);

        // zero register
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0};
        wr_data = {32'h0, 32'hFFFFFFFF};
        iss_en = 1'b1; iss_addr = 5'd0;
        rd(5'd0, 5'd0);
        check("z_byp_zr", rd_data[31:0], 32'h0);
        check("z_byp_nz", rd_data_z[31:0], 32'hFFFFFFFF);
        step();
        rd(5'd0, 5'd0);
        check("z_data_zr", rd_data[31:0], 32'h0);
        check("z_busy_zr", 32'(rd_busy), 32'd0);
        check("z_cnt_zr", 32'(busy_count), 32'd0);
        check("z_data_nz", rd_data_z[31:0], 32'hFFFFFFFF);
        check("z_busy_nz", 32'(rd_busy_z), 32'd3);
        check("z_cnt_nz", 32'(busy_count_z), 32'd1);

        // scoreboard lifecycle
        issue(5'd7);
        check("lc_cnt1", 32'(busy_count), 32'd1);
        issue(5'd9);
        check("lc_cnt2", 32'(busy_count), 32'd2);
        rd(5'd7, 5'd9);
        check("lc_busy", 32'(rd_busy), 32'd3);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd7};
        wr_data = {32'h0, 32'h77};
        rd(5'd7, 5'd9);
        check("lc_wr_busy", 32'(rd_busy), 32'd2);
        check("lc_wr_data", rd_data[31:0], 32'h77);
        step();
        rd(5'd7, 5'd9);
        check("lc_cnt_after", 32'(busy_count), 32'd1);
        check("lc_busy_after", 32'(rd_busy), 32'd2);

        // same-cycle issue and write of already-busy r4
        issue(5'd4);
        check("sc_cnt_pre", 32'(busy_count), 32'd2);
        iss_en = 1'b1; iss_addr = 5'd4;
        wr_en = 2'b10; wr_addr = {5'd4, 5'd0};
        wr_data = {32'h44, 32'h0};
        step();
        rd(5'd4, 5'd9);
        check("sc_cnt", 32'(busy_count), 32'd2);
        check("sc_busy", 32'(rd_busy), 32'd3);
        check("sc_data", rd_data[31:0], 32'h44);

        // flush with a simultaneous issue
        issue(5'd2);
        issue(5'd6);
        issue(5'd8);
        check("fl_cnt_pre", 32'(busy_count), 32'd5);
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd10;
        step();
        rd(5'd10, 5'd2);
        check("fl_cnt", 32'(busy_count), 32'd0);
        check("fl_busy_a", 32'(rd_busy), 32'd0);
        check("fl_cnt_nz", 32'(busy_count_z), 32'd0);
        rd(5'd6, 5'd8);
        check("fl_busy_b", 32'(rd_busy), 32'd0);
        rd(5'd3, 5'd7);
        check("fl_keep_r3", rd_data[31:0], 32'h22);
        check("fl_keep_r7", rd_data[63:32], 32'h77);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
